mips_instr_encoder: RTL
=======================

# mips_instr_encoder

Writer-side counterpart of the MIPS-lite decode stage: accepts instruction fields over a valid/ready handshake, packs them into the 32-bit instruction word the decode stage expects, and streams the word big-endian into the 4096-byte instruction/data memory. Sits between the testbench program source (or a trace loader) and the memory image the pipelined simulator fetches from.

## Interface
- ADDR_W, 12, byte-address width (4096-byte memory).
- BASE_ADDR, 0, first byte address written after reset/clear.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- clear  in  1  synchronous restart (address, count, flags).
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept fields.
- in_opcode  in  6  opcode (ADD=0 … HALT=17).
- in_rs / in_rt / in_rd  in  5 each  register indices.
- in_imm  in  16  immediate / branch offset, raw bits.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- enc_word  out  32  last encoded word.
- enc_valid  out  1  one-cycle pulse with new enc_word.
- instr_count  out  16  instructions written since reset/clear.
- illegal  out  1  sticky: opcode > 17 received.
- wrapped  out  1  sticky: mem_addr wrapped past 2^ADDR_W-1.
- halted  out  1  HALT has been written.

## Operation
- Encoding (bits [31:26]=opcode always):
  - R-type ADD/SUB/MUL/OR/AND/XOR: {op, rs, rt, rd, 11'b0}.
  - I-type ADDI/SUBI/MULI/ORI/ANDI/XORI/LOAD/STORE, and BEQ: {op, rs, rt, imm}.
  - BZ: {op, rs, 5'b0, imm}. JR: {op, rs, 21'b0}. HALT: {op, 26'b0}.
  - Unused input fields are ignored, not checked.
- FSM states: IDLE, WR0, WR1, WR2, WR3, HALTED.
  - IDLE: in_ready=1. Handshake with legal opcode -> latch word, go WR0. Illegal opcode -> consumed, dropped, illegal<=1, stay IDLE, no write, count unchanged.
  - WRn: mem_we=1, mem_addr=ptr, mem_wdata=word byte n (WR0 = [31:24]); ptr<=ptr+1. WR3 -> instr_count+1; next HALTED if opcode was HALT, else IDLE.
  - HALTED: in_ready=0, halted=1; leaves only on clear or reset.
- ptr wraps modulo 2^ADDR_W; the increment from all-ones sets wrapped.
- instr_count saturates at 16'hFFFF.
- clear: overrides state; next cycle IDLE, ptr=BASE_ADDR, count=0, illegal/wrapped/halted=0, enc_valid=0; any in-progress byte sequence is aborted (remaining bytes not written). clear and handshake in same cycle: handshake ignored.

## Timing
- Reset values: in_ready=1 (state IDLE), mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, enc_word=0, enc_valid=0, instr_count=0, illegal=0, wrapped=0, halted=0.
- in_ready = (state==IDLE); no combinational path from in_valid.
- Handshake at edge N: enc_word/enc_valid valid cycle N+1; mem_we high N+1..N+4 at ptr..ptr+3; in_ready low N+1..N+4, high N+5 unless halted.
- instr_count increments at the edge ending WR3 (visible N+5).
- Throughput: one instruction per 5 cycles.
- Reset asserted mid-sequence: immediate return to reset values; partial word stays in memory.

## Structure
- Shared package: opcode parameters (existing), state enum, function encode_instr(opcode, rs, rt, rd, imm) returning 32 bits plus an is_legal_opcode function, so the decode stage and benches share one definition.
- No sub-module; single module with FSM, pointer/counter registers, byte mux.

## Test plan
- ADD op=0 rs=1 rt=2 rd=3 -> enc_word 0x00221800; bytes 00,22,18,00 at 0..3; instr_count=1.
- ADDI op=1 rs=1 rt=2 imm=0xFFFF, back-to-back after ADD with in_valid held -> accepted at N+5, word 0x0422FFFF at 4..7.
- HALT op=17 -> word 0x44000000 written, halted=1, in_ready stays 0 with in_valid high for 20 cycles; clear -> in_ready=1, ptr=0.
- Opcode 20 -> no mem_we, illegal=1, count unchanged, next legal instruction written at unchanged address.
- BASE_ADDR=4092, two ADDs -> second writes 0..3, wrapped=1.
- rst_n low during WR2 -> outputs at reset values asynchronously; after release first instruction written at BASE_ADDR.

Source files
------------

// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS-lite definitions: opcode numbers, encoder FSM states and the
// field-packing function used by both the encoder and the decode stage.
package mips_instr_encoder_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SUBI  = 6'd3;
    localparam logic [5:0] OP_MUL   = 6'd4;
    localparam logic [5:0] OP_MULI  = 6'd5;
    localparam logic [5:0] OP_OR    = 6'd6;
    localparam logic [5:0] OP_ORI   = 6'd7;
    localparam logic [5:0] OP_AND   = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd9;
    localparam logic [5:0] OP_XOR   = 6'd10;
    localparam logic [5:0] OP_XORI  = 6'd11;
    localparam logic [5:0] OP_LOAD  = 6'd12;
    localparam logic [5:0] OP_STORE = 6'd13;
    localparam logic [5:0] OP_BZ    = 6'd14;
    localparam logic [5:0] OP_BEQ   = 6'd15;
    localparam logic [5:0] OP_JR    = 6'd16;
    localparam logic [5:0] OP_HALT  = 6'd17;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WR0    = 3'd1;
    localparam state_t ST_WR1    = 3'd2;
    localparam state_t ST_WR2    = 3'd3;
    localparam state_t ST_WR3    = 3'd4;
    localparam state_t ST_HALTED = 3'd5;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_BZ,
        FMT_JR,
        FMT_NONE
    } fmt_e;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op <= OP_HALT);
    endfunction

    function automatic fmt_e opcode_fmt(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR:          return FMT_R;
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI,
            OP_LOAD, OP_STORE, OP_BEQ:                              return FMT_I;
            OP_BZ:                                                  return FMT_BZ;
            OP_JR:                                                  return FMT_JR;
            default:                                                return FMT_NONE;
        endcase
    endfunction

    // Fields a format does not use are dropped, never checked.
    function automatic logic [31:0] encode_instr(input logic [5:0]  op,
                                                 input logic [4:0]  rs,
                                                 input logic [4:0]  rt,
                                                 input logic [4:0]  rd,
                                                 input logic [15:0] imm);
        case (opcode_fmt(op))
            FMT_R:   return {op, rs, rt, rd, 11'b0};
            FMT_I:   return {op, rs, rt, imm};
            FMT_BZ:  return {op, rs, 5'b0, imm};
            FMT_JR:  return {op, rs, 21'b0};
            default: return {op, 26'b0};
        endcase
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Field-input handshake plus byte-write memory port and status of the encoder.
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [31:0]       enc_word;
    logic              enc_valid;
    logic [15:0]       instr_count;
    logic              illegal;
    logic              wrapped;
    logic              halted;

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, enc_word, enc_valid,
               instr_count, illegal, wrapped, halted
    );

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata, enc_word, enc_valid,
               instr_count, illegal, wrapped, halted
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs MIPS-lite instruction fields into 32-bit words and writes each word
// big-endian, one byte per cycle, into the instruction/data memory image.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    mips_instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [31:0]       word_q,      word_d;
    logic              enc_valid_q, enc_valid_d;
    logic [15:0]       count_q,     count_d;
    logic              illegal_q,   illegal_d;
    logic              wrapped_q,   wrapped_d;
    logic              halted_q,    halted_d;
    logic              in_ready_q,  in_ready_d;
    logic              mem_we_q,    mem_we_d;
    logic [7:0]        wdata_q,     wdata_d;

    function automatic logic is_wr_state(input state_t st);
        return (st == ST_WR0) || (st == ST_WR1) || (st == ST_WR2) || (st == ST_WR3);
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input state_t st);
        case (st)
            ST_WR0:  return w[31:24];
            ST_WR1:  return w[23:16];
            ST_WR2:  return w[15:8];
            ST_WR3:  return w[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Next-state, pointer/counter/flag updates, and registered output values.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        count_d     = count_q;
        illegal_d   = illegal_q;
        wrapped_d   = wrapped_q;
        enc_valid_d = 1'b0;

        if (clear) begin
            state_d   = ST_IDLE;
            ptr_d     = BASE_PTR;
            count_d   = 16'd0;
            illegal_d = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_legal_opcode(bus.in_opcode)) begin
                            word_d      = encode_instr(bus.in_opcode, bus.in_rs, bus.in_rt,
                                                       bus.in_rd, bus.in_imm);
                            enc_valid_d = 1'b1;
                            state_d     = ST_WR0;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WR0: state_d = ST_WR1;
                ST_WR1: state_d = ST_WR2;
                ST_WR2: state_d = ST_WR3;
                ST_WR3: begin
                    state_d = (word_q[31:26] == OP_HALT) ? ST_HALTED : ST_IDLE;
                    count_d = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase

            // Every write cycle consumes one address; stepping off all-ones wraps.
            if (is_wr_state(state_q)) begin
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == PTR_MAX) begin
                    wrapped_d = 1'b1;
                end else begin
                    wrapped_d = wrapped_q;
                end
            end else begin
                ptr_d = ptr_q;
            end
        end

        mem_we_d   = is_wr_state(state_d);
        wdata_d    = byte_of(word_d, state_d);
        in_ready_d = (state_d == ST_IDLE);
        halted_d   = (state_d == ST_HALTED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE_PTR;
            word_q      <= 32'h0000_0000;
            enc_valid_q <= 1'b0;
            count_q     <= 16'd0;
            illegal_q   <= 1'b0;
            wrapped_q   <= 1'b0;
            halted_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            wdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            enc_valid_q <= enc_valid_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
            wrapped_q   <= wrapped_d;
            halted_q    <= halted_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = ptr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.enc_word    = word_q;
    assign bus.enc_valid   = enc_valid_q;
    assign bus.instr_count = count_q;
    assign bus.illegal     = illegal_q;
    assign bus.wrapped     = wrapped_q;
    assign bus.halted      = halted_q;

endmodule
